sha256_block_ctrl: RTL and testbench
====================================

SHA256_BLOCK_CTRL -- requirements
Module: sha256_block_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: max cycles from core_start to core_busy rising before error.
REQ-002 SHALL have port io_mainClk  input  1  single clock; all flops on rising edge.
REQ-003 SHALL have port io_systemReset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port word_valid  input  1  host offers one 32-bit message word.
REQ-005 SHALL have port word_data  input  32  message word, big-endian order within block.
REQ-006 SHALL have port word_first  input  1  marks word 0 of first block of a message; sampled only with word index 0.
REQ-007 SHALL have port word_ready  output  1  controller accepts word this cycle.
REQ-008 SHALL have port abort  input  1  synchronous pulse; cancels current operation.
REQ-009 SHALL have port core_data_in  output  512  assembled block to core; word 0 in bits [511:480].
REQ-010 SHALL have port core_init_iv  output  1  one-cycle pulse; core loads IV.
REQ-011 SHALL have port core_init_message  output  1  one-cycle pulse; core loads core_data_in.
REQ-012 SHALL have port core_start  output  1  one-cycle pulse; core begins compression.
REQ-013 SHALL have port core_cmd  output  3  3'b001 while core_start is high, else 3'b000.
REQ-014 SHALL have port core_busy  input  1  core compressing.
REQ-015 SHALL have port core_data_out  input  256  core digest, valid after core_busy falls.
REQ-016 SHALL have port digest  output  256  registered digest of last completed block.
REQ-017 SHALL have port digest_valid  output  1  one-cycle pulse when digest updates.
REQ-018 SHALL have port error  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement states LOAD, IV, MSG, GO, WAIT_HI, WAIT_LO, DONE, ERR.
REQ-020 SHALL drive word_ready=1 only in LOAD; a word is accepted on word_valid & word_ready, one per cycle, 4-bit index counter 0..15.
REQ-021 SHALL latch word_first only when index=0 is accepted; word_first at other indices ignored.
REQ-022 SHALL, on accepting word 15 at cycle t, go to IV if latched first=1 else MSG; index wraps to 0.
REQ-023 SHALL pulse core_init_iv in IV (t+1), core_init_message in MSG, core_start with core_cmd=3'b001 in GO; first block: start at t+3, otherwise t+2.
REQ-024 SHALL in WAIT_HI count cycles; on core_busy=1 go WAIT_LO; if count reaches TIMEOUT_CYC go ERR, set error.
REQ-025 SHALL in WAIT_LO, on core_busy=0, go DONE; DONE captures core_data_out into digest, pulses digest_valid, returns to LOAD next cycle.
REQ-026 SHALL hold core_data_in stable from word-15 acceptance until DONE.
REQ-027 SHALL in ERR hold word_ready=0 and all core pulses 0 until abort.
REQ-028 SHALL on abort in any state return to LOAD, clear index, latched first, timer and error; abort wins over simultaneous word acceptance (word discarded); digest unchanged.

Reset
REQ-029 SHALL on io_systemReset asynchronously enter LOAD, clear index, timer, latched first, core_data_in, digest, error; all pulse outputs 0, core_cmd 3'b000.
REQ-030 SHALL, when reset asserts mid-WAIT, not pulse digest_valid after release; next block restarts from word 0.

Structure
REQ-031 SHALL place state enum, WORDS_PER_BLOCK=16 and CMD_SHA256=3'b001 in shared package sha256_ctrl_pkg.
REQ-032 SHALL instantiate one sub-module sha256_block_buffer (16x32 word register file with index write, 512-bit flattened output); FSM, timer and digest register stay top-level.

Verification
REQ-033 SHALL check "abc": words 0x61626380, 14x0, 0x00000018, first=1 with real core -> one core_init_iv, digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, digest_valid one cycle.
REQ-034 SHALL check two-block message (first=1 then first=0) -> core_init_iv pulses exactly once; second core_start 2 cycles after its word 15.
REQ-035 SHALL check core stub never raising busy, TIMEOUT_CYC=8 -> error=1 at 8 cycles after core_start, word_ready=0 until abort, then error=0.
REQ-036 SHALL check abort after 7 words, then a full "abc" block -> correct digest, no stale words in core_data_in.
REQ-037 SHALL check reset in WAIT_LO -> all outputs at reset values immediately, no digest_valid afterward.
REQ-038 SHALL check word_valid held high continuously -> exactly 16 words accepted, word_ready low until DONE returns to LOAD.

Source files
------------

// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 block controller and its word buffer.
// Holds the FSM state encoding, block geometry and the core command code.
package sha256_ctrl_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int IDX_W           = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;
    localparam int DIGEST_W        = 256;

    localparam logic [2:0] CMD_SHA256 = 3'b001;
    localparam logic [2:0] CMD_IDLE   = 3'b000;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_IV      = 3'd1,
        ST_MSG     = 3'd2,
        ST_GO      = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_WAIT_LO = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } ctrl_state_e;

    function automatic logic is_last_word(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(WORDS_PER_BLOCK - 1);
    endfunction

endpackage

// File: rtl/sha256_block_buffer.sv
// 16x32 message word register file written by index; presents the block flattened
// with word 0 in the most significant 32 bits, as the core expects big-endian order.
module sha256_block_buffer
    import sha256_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [WORD_W-1:0]  wr_data,
    output logic [BLOCK_W-1:0] block
);

    logic [WORD_W-1:0] mem_q [WORDS_PER_BLOCK];
    logic [WORD_W-1:0] mem_d [WORDS_PER_BLOCK];

    // Clearing on cancel keeps a half-written block from leaking into the next one.
    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                mem_d[i] = '0;
            end
        end else if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        block = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            block[BLOCK_W-1-WORD_W*i -: WORD_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/sha256_block_ctrl.sv
// Collects 16 message words, sequences IV/message/start pulses to a SHA-256 core,
// waits out its busy window with a start timeout, and registers the resulting digest.
module sha256_block_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                io_mainClk,
    input  logic                io_systemReset,
    input  logic                word_valid,
    input  logic [WORD_W-1:0]   word_data,
    input  logic                word_first,
    output logic                word_ready,
    input  logic                abort,
    output logic [BLOCK_W-1:0]  core_data_in,
    output logic                core_init_iv,
    output logic                core_init_message,
    output logic                core_start,
    output logic [2:0]          core_cmd,
    input  logic                core_busy,
    input  logic [DIGEST_W-1:0] core_data_out,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                error,
    output logic [2:0]          dbg_state
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    ctrl_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                first_q, first_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                error_q, error_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic                digest_valid_q, digest_valid_d;
    logic                wr_en;

    // Handshake: a word moves when word_valid and word_ready are both high at a
    // rising edge; word_ready depends only on state, never on word_valid.
    assign word_ready = (state_q == ST_LOAD);
    assign wr_en      = word_valid & word_ready & ~abort;

    sha256_block_buffer u_buffer (
        .clk     (io_mainClk),
        .rst     (io_systemReset),
        .clr     (abort),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (word_data),
        .block   (core_data_in)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        first_d        = first_q;
        tmr_d          = tmr_q;
        error_d        = error_q;
        digest_d       = digest_q;
        digest_valid_d = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (wr_en) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == '0) begin
                        first_d = word_first;
                    end
                    if (is_last_word(idx_q)) begin
                        state_d = first_q ? ST_IV : ST_MSG;
                    end
                end
            end
            ST_IV:  state_d = ST_MSG;
            ST_MSG: state_d = ST_GO;
            ST_GO: begin
                // The start cycle itself counts as the first cycle of the timeout.
                tmr_d   = TMR_W'(1);
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (core_busy) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                    if (tmr_q >= TMR_W'(TIMEOUT_CYC - 1)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (!core_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                digest_d       = core_data_out;
                digest_valid_d = 1'b1;
                state_d        = ST_LOAD;
            end
            ST_ERR: state_d = ST_ERR;
            default: state_d = ST_LOAD;
        endcase

        // Cancel overrides everything, including a word arriving in the same cycle.
        if (abort) begin
            state_d        = ST_LOAD;
            idx_d          = '0;
            first_d        = 1'b0;
            tmr_d          = '0;
            error_d        = 1'b0;
            digest_d       = digest_q;
            digest_valid_d = 1'b0;
        end
    end

    always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            state_q        <= ST_LOAD;
            idx_q          <= '0;
            first_q        <= 1'b0;
            tmr_q          <= '0;
            error_q        <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            first_q        <= first_d;
            tmr_q          <= tmr_d;
            error_q        <= error_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    assign core_init_iv      = (state_q == ST_IV);
    assign core_init_message = (state_q == ST_MSG);
    assign core_start        = (state_q == ST_GO);
    assign core_cmd          = (state_q == ST_GO) ? CMD_SHA256 : CMD_IDLE;
    assign digest            = digest_q;
    assign digest_valid      = digest_valid_q;
    assign error             = error_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Bench for sha256_block_ctrl: a behavioural SHA-256 core answers the controller,
// expected blocks and digests go into queues and a negedge monitor checks them.
module tb_sha256_block_ctrl;
    import sha256_ctrl_pkg::*;

    localparam int TMO      = 8;
    localparam int CORE_LAT = 6;
    localparam logic [255:0] SHA_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    // ---------------- clock / reset / DUT ----------------
    logic         io_mainClk = 1'b0;
    logic         io_systemReset;
    logic         word_valid, word_first, word_ready, abort;
    logic [31:0]  word_data;
    logic [511:0] core_data_in;
    logic         core_init_iv, core_init_message, core_start, core_busy;
    logic [2:0]   core_cmd, dbg_state;
    logic [255:0] core_data_out, digest;
    logic         digest_valid, error;

    always #5 io_mainClk = ~io_mainClk;

    sha256_block_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .io_mainClk        (io_mainClk),
        .io_systemReset    (io_systemReset),
        .word_valid        (word_valid),
        .word_data         (word_data),
        .word_first        (word_first),
        .word_ready        (word_ready),
        .abort             (abort),
        .core_data_in      (core_data_in),
        .core_init_iv      (core_init_iv),
        .core_init_message (core_init_message),
        .core_start        (core_start),
        .core_cmd          (core_cmd),
        .core_busy         (core_busy),
        .core_data_out     (core_data_out),
        .digest            (digest),
        .digest_valid      (digest_valid),
        .error             (error),
        .dbg_state         (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [256:0] exp_q[$];   // {compare_enable, digest}
    logic [511:0] blk_q[$];
    int cyc_n = 0, iv_cnt = 0, iv_cyc = 0, start_cnt = 0, start_cyc = 0, dv_cnt = 0;
    logic dv_prev = 1'b0;
    bit core_alive = 1'b1;
    logic [31:0] blk_w [16];
    logic [255:0] core_h;
    logic [511:0] core_m;
    int core_cnt = 0;

    task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
                 + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96], f + hin[95:64], g + hin[63:32], h + hin[31:0]};
    endfunction

    // ---------------- behavioural core ----------------
    always @(negedge io_mainClk) begin
        if (io_systemReset) begin
            core_busy = 1'b0;
            core_cnt  = 0;
        end else begin
            if (core_init_iv) core_h = SHA_IV;
            if (core_init_message) core_m = core_data_in;
            if (core_busy) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_busy     = 1'b0;
                    core_h        = sha_compress(core_h, core_m);
                    core_data_out = core_h;
                end
            end else if (core_start && core_alive) begin
                core_busy = 1'b1;
                core_cnt  = CORE_LAT;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge io_mainClk) begin
        logic [256:0] e;
        logic [511:0] bexp;
        cyc_n++;
        if (core_init_iv) begin
            iv_cnt++;
            iv_cyc = cyc_n;
        end
        if (core_init_message) check_int("cmd_idle_in_msg", int'(core_cmd), int'(CMD_IDLE));
        if (core_start) begin
            start_cnt++;
            start_cyc = cyc_n;
            check_int("cmd_at_start", int'(core_cmd), int'(CMD_SHA256));
            tests++;
            if (blk_q.size() == 0) begin
                fails++;
                $display("FAIL start_unexpected: got core_start expected none");
            end else begin
                bexp = blk_q.pop_front();
                if (core_data_in !== bexp) begin
                    fails++;
                    $display("FAIL block_at_start: got %h expected %h", core_data_in, bexp);
                end
            end
        end
        if (digest_valid) begin
            dv_cnt++;
            check_bit("digest_valid_one_cycle", dv_prev, 1'b0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL digest_unexpected: got %h expected no digest_valid", digest);
            end else begin
                e = exp_q.pop_front();
                if (e[256]) check_vec("digest", digest, e[255:0]);
            end
        end
        dv_prev = digest_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge io_mainClk);
        #1;
    endtask

    function automatic logic [511:0] blk_flat();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = blk_w[i];
        return r;
    endfunction

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk_w[i] = 32'h0;
        blk_w[0]  = 32'h61626380;
        blk_w[15] = 32'h00000018;
    endtask

    task automatic load_two(input bit second);
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'h61 + 8'(i);
            blk_w[i] = (!second && i < 14) ? {b, b + 8'd1, b + 8'd2, b + 8'd3} : 32'h0;
        end
        if (second) blk_w[15] = 32'h000001c0;
        else        blk_w[14] = 32'h80000000;
    endtask

    // noise_idx: a later word index that also carries word_first=1 (must be ignored).
    task automatic send_words(input int n, input bit first, input int noise_idx, output int t_last);
        int w;
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            word_valid = 1'b1;
            word_data  = blk_w[i];
            word_first = (i == 0) ? first : (i == noise_idx);
            w = 0;
            while (!word_ready && w < 100) begin
                tick();
                w++;
            end
            if (!word_ready) begin
                tests++;
                fails++;
                $display("FAIL word_ready_wait: got word_ready=0 for %0d cycles expected 1", w);
            end
            @(posedge io_mainClk);
            t_last = cyc_n;
        end
        tick();
        word_valid = 1'b0;
        word_first = 1'b0;
    endtask

    task automatic wait_start(input int target);
        int w = 0;
        while (start_cnt < target && w < 200) begin
            tick();
            w++;
        end
        check_bit("core_start_seen", start_cnt >= target, 1'b1);
    endtask

    task automatic wait_dv(input int target);
        int w = 0;
        while (dv_cnt < target && w < 200) begin
            tick();
            w++;
        end
        check_bit("digest_valid_seen", dv_cnt >= target, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_word_ready"}, word_ready, 1'b1);
        check_bit({tag, "_init_iv"}, core_init_iv, 1'b0);
        check_bit({tag, "_init_msg"}, core_init_message, 1'b0);
        check_bit({tag, "_start"}, core_start, 1'b0);
        check_int({tag, "_cmd"}, int'(core_cmd), 0);
        check_vec({tag, "_digest"}, digest, 256'h0);
        check_bit({tag, "_digest_valid"}, digest_valid, 1'b0);
        check_bit({tag, "_error"}, error, 1'b0);
        check_vec({tag, "_data_in_hi"}, core_data_in[511:256], 256'h0);
        check_vec({tag, "_data_in_lo"}, core_data_in[255:0], 256'h0);
        check_int({tag, "_state"}, int'(dbg_state), int'(ST_LOAD));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 500us");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t, t2, s, iv0, st0, dv0, acc, n;
        io_systemReset = 1'b1;
        word_valid = 1'b0; word_data = '0; word_first = 1'b0; abort = 1'b0;
        core_busy = 1'b0; core_data_out = '0; core_h = '0; core_m = '0;
        repeat (3) tick();
        check_reset_outputs("rst_held");
        io_systemReset = 1'b0;
        tick();
        check_reset_outputs("post_rst");

        // single-block "abc"
        load_abc();
        blk_q.push_back(blk_flat());
        exp_q.push_back({1'b1, ABC_DIG});
        iv0 = iv_cnt; st0 = start_cnt; dv0 = dv_cnt;
        send_words(16, 1'b1, -1, t);
        wait_start(st0 + 1);
        check_int("abc_iv_at_t1", iv_cyc - t, 1);
        check_int("abc_start_at_t3", start_cyc - t, 3);
        wait_dv(dv0 + 1);
        check_int("abc_iv_count", iv_cnt - iv0, 1);
        repeat (3) tick();
        check_vec("abc_digest_held", digest, ABC_DIG);

        // two-block message, stray word_first mid-block on the second block
        iv0 = iv_cnt; st0 = start_cnt; dv0 = dv_cnt;
        load_two(1'b0);
        blk_q.push_back(blk_flat());
        exp_q.push_back({1'b0, 256'h0});
        send_words(16, 1'b1, -1, t);
        load_two(1'b1);
        blk_q.push_back(blk_flat());
        exp_q.push_back({1'b1, TWO_DIG});
        send_words(16, 1'b0, 5, t2);
        wait_start(st0 + 2);
        check_int("two_second_start_at_t2", start_cyc - t2, 2);
        wait_dv(dv0 + 2);
        check_int("two_iv_count", iv_cnt - iv0, 1);

        // timeout with a core that never goes busy
        core_alive = 1'b0;
        load_abc();
        blk_q.push_back(blk_flat());
        st0 = start_cnt;
        send_words(16, 1'b1, -1, t);
        wait_start(st0 + 1);
        s = start_cyc;
        n = 0;
        while (cyc_n < s + 7 && n < 50) begin
            tick();
            n++;
        end
        check_bit("tmo_error_before", error, 1'b0);
        tick();
        check_bit("tmo_error_at_8", error, 1'b1);
        word_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_bit("tmo_word_ready_low", word_ready, 1'b0);
            check_int("tmo_no_pulses", int'({core_init_iv, core_init_message, core_start}), 0);
            tick();
        end
        word_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_bit("tmo_error_cleared", error, 1'b0);
        check_bit("tmo_word_ready_back", word_ready, 1'b1);
        check_vec("tmo_digest_kept", digest, TWO_DIG);
        core_alive = 1'b1;

        // abort after 7 words, abort colliding with an offered word, then full "abc"
        load_abc();
        send_words(7, 1'b1, -1, t);
        word_valid = 1'b1; word_data = 32'hdeadbeef; abort = 1'b1;
        tick();
        abort = 1'b0; word_valid = 1'b0;
        blk_q.push_back(blk_flat());
        exp_q.push_back({1'b1, ABC_DIG});
        dv0 = dv_cnt;
        send_words(16, 1'b1, -1, t);
        wait_dv(dv0 + 1);

        // reset while waiting for busy to fall
        load_abc();
        blk_q.push_back(blk_flat());
        st0 = start_cnt;
        send_words(16, 1'b1, -1, t);
        wait_start(st0 + 1);
        tick();
        tick();
        check_int("rst_mid_in_wait_lo", int'(dbg_state), int'(ST_WAIT_LO));
        #2 io_systemReset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        tick();
        io_systemReset = 1'b0;
        dv0 = dv_cnt;
        repeat (20) tick();
        check_int("rst_no_digest_valid", dv_cnt - dv0, 0);

        // word_valid held high across a whole block
        load_abc();
        blk_q.push_back(blk_flat());
        exp_q.push_back({1'b1, ABC_DIG});
        word_valid = 1'b1; word_first = 1'b1;
        acc = 0; n = 0;
        while (!digest_valid && n < 200) begin
            word_data = blk_w[acc % 16];
            if (word_ready) acc++;
            tick();
            n++;
        end
        word_valid = 1'b0; word_first = 1'b0;
        check_bit("held_digest_valid_seen", digest_valid, 1'b1);
        check_int("held_words_accepted", acc, 16);

        repeat (4) tick();
        check_int("exp_q_drained", exp_q.size(), 0);
        check_int("blk_q_drained", blk_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
